// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, full 2*WIDTH-bit product.
// Optional two's-complement support is compiled in with `define MULT_SIGNED_EN.
module seq_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_e;

   state_e            state_q,  state_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [WIDTH-1:0]  mcand_q,  mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q,    acc_d;
   logic [PW-1:0]     p_q,      p_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;

   logic [WIDTH:0]    sum;
   logic [PW-1:0]     acc_step;
   logic [PW-1:0]     result;
   logic [WIDTH-1:0]  a_ld;
   logic [WIDTH-1:0]  b_ld;
   logic              accept;

   // One iteration: conditional add into the upper WIDTH+1 bits, then shift right.
   always_comb begin
      sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : WIDTH'(0))};
      acc_step = {sum, acc_q[WIDTH-1:1]};
   end

`ifdef MULT_SIGNED_EN
   logic neg_q, neg_d;
   logic a_neg, b_neg;

   // Operands become magnitudes at load; the product is negated on the way into p.
   always_comb begin
      a_neg  = signed_mode & a[WIDTH-1];
      b_neg  = signed_mode & b[WIDTH-1];
      a_ld   = a_neg ? (~a + WIDTH'(1)) : a;
      b_ld   = b_neg ? (~b + WIDTH'(1)) : b;
      result = neg_q ? (~acc_step + PW'(1)) : acc_step;
   end
`else
   logic unused_signed_mode;
   assign unused_signed_mode = signed_mode;

   always_comb begin
      a_ld   = a;
      b_ld   = b;
      result = acc_step;
   end
`endif

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      p_d      = p_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      accept   = 1'b0;
`ifdef MULT_SIGNED_EN
      neg_d    = neg_q;
`endif

      case (state_q)
         S_IDLE: accept = start;
         S_CALC: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            busy_d   = 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_DONE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               p_d     = result;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            accept  = start;
         end
         default: state_d = S_IDLE;
      endcase

      // Load is shared by IDLE and DONE so back-to-back starts lose no cycle.
      if (accept) begin
         state_d  = S_CALC;
         busy_d   = 1'b1;
         mcand_d  = a_ld;
         mplier_d = b_ld;
         acc_d    = '0;
         cnt_d    = '0;
`ifdef MULT_SIGNED_EN
         neg_d    = (signed_mode & a[WIDTH-1]) ^ (signed_mode & b[WIDTH-1]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         p_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MULT_SIGNED_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         p_q      <= p_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MULT_SIGNED_EN
         neg_q    <= neg_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): vector table, corner sequences, random ops vs. arithmetic model.
module tb_seq_multiplier;

   localparam int unsigned W  = 8;
   localparam int unsigned PW = 2 * W;
`ifdef MULT_SIGNED_EN
   localparam bit SE = 1'b1;
`else
   localparam bit SE = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          sm;
      logic [PW-1:0] exp_s;   // expected with signed support built in
      logic [PW-1:0] exp_u;   // expected without it
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sm;
   logic          busy;
   logic          done;
   logic [PW-1:0] p;

   int n_cmp  = 0;
   int n_fail = 0;

   vec_t vecs[10];

   seq_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (sm),
      .busy        (busy),
      .done        (done),
      .p           (p)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer product, two's complement only when honoured.
   function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
      longint px, py;
      if (SE && s) begin
         px = longint'($signed(x));
         py = longint'($signed(y));
      end else begin
         px = longint'({56'd0, x});
         py = longint'({56'd0, y});
      end
      return PW'(px * py);
   endfunction

   // Drive start for one cycle from a negedge; scramble operands afterwards.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a     = x;
      b     = y;
      sm    = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sm    = 1'($urandom);
   endtask

   // Called one negedge after the start edge; ends in the done cycle.
   task automatic wait_result(input string name, input logic [PW-1:0] exp);
      int            bad;
      logic [PW-1:0] p0;
      bad = 0;
      p0  = p;
      for (int i = 0; i < int'(W); i++) begin
         if (busy !== 1'b1 || done !== 1'b0 || p !== p0) bad++;
         @(negedge clk);
      end
      check({name, "_busy"}, 32'(bad), 32'd0);
      check({name, "_done"}, {30'd0, busy, done}, 32'd1);
      check({name, "_p"}, 32'(p), 32'(exp));
   endtask

   task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic [PW-1:0] exp);
      issue(x, y, s);
      wait_result(name, exp);
      @(negedge clk);
      check({name, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int            cyc;
      int            bad;
      logic [W-1:0]  rx, ry;
      logic          rs;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sm    = 1'b0;

      vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 16'h008F};
      vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 16'hFE01};
      vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000, 16'h0000};
      vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 16'h04F1};
      vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000, 16'h4000};
      vecs[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 16'hFE01};
      vecs[6] = '{8'h7F,  8'h80,  1'b1, 16'hC080, 16'h3F80};
      vecs[7] = '{8'hFD,  8'd5,   1'b0, 16'h04F1, 16'h04F1};
      vecs[8] = '{8'd255, 8'd1,   1'b0, 16'h00FF, 16'h00FF};
      vecs[9] = '{8'd1,   8'hFF,  1'b1, 16'hFFFF, 16'h00FF};

      repeat (2) @(negedge clk);
      check("reset_state", {14'd0, busy, done, p}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {14'd0, busy, done, p}, 32'd0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                SE ? vecs[i].exp_s : vecs[i].exp_u);

      // Start during CALC is ignored; then a start in the done cycle chains back-to-back.
      issue(8'd7, 8'd6, 1'b0);
      repeat (2) @(negedge clk);
      a     = 8'd9;
      b     = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (done !== 1'b1 && cyc < int'(4 * W)) begin
         @(negedge clk);
         cyc++;
      end
      check("ignored_start_latency", 32'(cyc), 32'(W - 3));
      check("ignored_start_p", 32'(p), 32'd42);
      issue(8'd2, 8'd3, 1'b0);
      wait_result("back_to_back", 16'd6);
      @(negedge clk);
      check("back_to_back_idle", {30'd0, busy, done}, 32'd0);

      // Reset in the 4th CALC cycle aborts with no done.
      issue(8'd5, 8'd7, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort", {14'd0, busy, done, p}, 32'd0);
      bad = 0;
      repeat (2 * W) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("rst_no_done", 32'(bad), 32'd0);
      run_op("after_rst", 8'd3, 8'd4, 1'b0, 16'd12);

      // Random operations, randomly back-to-back or with idle gaps.
      for (int i = 0; i < 40; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         rs = 1'($urandom);
         if (i % 8 == 0) rx = 8'h80;
         issue(rx, ry, rs);
         wait_result($sformatf("rand%0d", i), model(rx, ry, rs));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
